// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, converter FSM states and display glyph codes.
package bcd_pkg;
    localparam int BCD_WIDTH = 4;
    localparam logic [BCD_WIDTH-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [BCD_WIDTH-1:0] BCD_CORR = 4'd3;
    // Non-decimal nibble codes the display side renders as sign/blank glyphs
    localparam logic [BCD_WIDTH-1:0] BCD_GLYPH_MINUS = 4'hA;
    localparam logic [BCD_WIDTH-1:0] BCD_GLYPH_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    function automatic logic digit_bad(input logic [BCD_WIDTH-1:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction
endpackage

// File: rtl/bcd_dabble_rev_step.sv
// bcd_dabble_rev_step: one reverse double-dabble iteration over {bcd, bin}:
// shift right by one, then subtract 3 from every BCD nibble that is now >= 8.
module bcd_dabble_rev_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5,
    localparam int W = DIGITS * BCD_WIDTH
) (
    input  logic [2*W-1:0] sr_i,
    output logic [2*W-1:0] sr_o
);
    logic [2*W-1:0] sh;

    assign sh = sr_i >> 1;
    assign sr_o[W-1:0] = sh[W-1:0];

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        logic [BCD_WIDTH-1:0] n;
        assign n = sh[W + d*BCD_WIDTH +: BCD_WIDTH];
        assign sr_o[W + d*BCD_WIDTH +: BCD_WIDTH] = (n >= 4'd8) ? n - BCD_CORR : n;
    end
endmodule

// File: rtl/bcd_to_bin_serial.sv
// bcd_to_bin_serial: serial signed BCD -> two's-complement converter, one bit per clock.
// Define BCD_DIGIT_CHECK_EN to add the digit_err output flagging input nibbles above 9.
module bcd_to_bin_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5,
    localparam int BIN_WIDTH = DIGITS * BCD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIN_WIDTH-1:0]   bcd_in,
    input  logic                   neg_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIN_WIDTH:0]     bin_out
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic                   digit_err
`endif
);
    localparam int CW = $clog2(BIN_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [2*BIN_WIDTH-1:0] sr_q, sr_d, sr_step;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   neg_q, neg_d;
    logic [BIN_WIDTH:0]     bin_q, bin_d, mag;

    bcd_dabble_rev_step #(.DIGITS(DIGITS)) u_step (
        .sr_i(sr_q),
        .sr_o(sr_step)
    );

    // Magnitude after the final iteration; zero-extended so negation never overflows
    assign mag       = {1'b0, sr_step[BIN_WIDTH-1:0]};
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign bin_out   = bin_q;

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d, bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | digit_bad(bcd_in[i*BCD_WIDTH +: BCD_WIDTH]);
    end

    assign digit_err = err_q;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        bin_d   = bin_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                sr_d    = {bcd_in, {BIN_WIDTH{1'b0}}};
                neg_d   = neg_in;
                cnt_d   = '0;
                state_d = CONVERT;
`ifdef BCD_DIGIT_CHECK_EN
                err_d   = bad;
`endif
            end
            CONVERT: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bin_d   = neg_q ? -mag : mag;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            bin_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            bin_q   <= bin_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// tb_bcd_to_bin_serial: directed checks of latency, handshakes, sign handling and reset abort.
module tb_bcd_to_bin_serial;
    localparam int BW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] bcd_in = '0;
    logic          neg_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW:0]   bin_out;
`ifdef BCD_DIGIT_CHECK_EN
    logic          digit_err;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bcd_to_bin_serial dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .bcd_in(bcd_in),
        .neg_in(neg_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bin_out(bin_out)
`ifdef BCD_DIGIT_CHECK_EN
        ,
        .digit_err(digit_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one input at a negedge; returns at the negedge right after the accepting edge
    task automatic start(input logic [BW-1:0] b, input logic n);
        @(negedge clk);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        bcd_in   = b;
        neg_in   = n;
        @(negedge clk);
        in_valid = 1'b0;
        bcd_in   = BW'($urandom);
        neg_in   = ~n;
    endtask

    task automatic finish_conv(input logic [BW:0] exp, input logic exp_err, input bit chk_bin,
                               input int hold, input bit poke, input bit chain,
                               input logic [BW-1:0] nb, input logic nn);
        int n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            if (poke && n == 5) begin
                chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
                in_valid = 1'b1;
                bcd_in   = 20'h11111;
            end
            if (poke && n == 9) in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("latency", n, BW);
        if (chk_bin) chk("bin_out", 32'(bin_out), 32'(exp));
`ifdef BCD_DIGIT_CHECK_EN
        chk("digit_err", {31'b0, digit_err}, {31'b0, exp_err});
`else
        if (exp_err) chk("digit_err_unsupported", 32'd0, 32'd1);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_bin", 32'(bin_out), 32'(exp));
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        if (chain) begin
            in_valid = 1'b1;
            bcd_in   = nb;
            neg_in   = nn;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_out_valid", {31'b0, out_valid}, 32'd0);
        chk("pop_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef BCD_DIGIT_CHECK_EN
        chk("pop_digit_err", {31'b0, digit_err}, 32'd0);
`endif
        if (chain) begin
            @(negedge clk);
            in_valid = 1'b0;
            bcd_in   = BW'($urandom);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        rst_n = 1'b1;

        start(20'h12345, 1'b0);
        finish_conv(21'h03039, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
        start(20'h00042, 1'b1);
        finish_conv(21'h1FFFD6, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
        start(20'h00000, 1'b1);
        finish_conv(21'h000000, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
        start(20'h99999, 1'b0);
        finish_conv(21'h1869F, 1'b0, 1'b1, 0, 1'b1, 1'b0, '0, 1'b0);

        // Stall 10 cycles in DONE, then pop with the next input already waiting
        start(20'h00500, 1'b1);
        finish_conv(21'h1FFE0C, 1'b0, 1'b1, 10, 1'b0, 1'b1, 20'h01000, 1'b0);
        finish_conv(21'h003E8, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);

        // Abort at cnt=7 with a nonzero previous result still on bin_out
        start(20'h00321, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_bin_out", 32'(bin_out), 32'd0);
`ifdef BCD_DIGIT_CHECK_EN
        chk("abort_digit_err", {31'b0, digit_err}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        start(20'h00007, 1'b0);
        finish_conv(21'h000007, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
        start(20'h0A000, 1'b0);
        finish_conv(21'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);
        start(20'h09000, 1'b0);
        finish_conv(21'h02328, 1'b0, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
